conv_window_addr_gen: RTL and testbench

//  Upstream sequencer for the 3x3 window RAM reader. Sweeps one feature map stored row-major in the conv RAM.
//  Per output pixel, issues nine tap addresses plus a one-cycle start to the reader, then waits for its

---
 rtl/conv_window_addr_gen.sv | 127 ++++++++++++
 tb/tb_conv_window_addr_gen.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_addr_gen.sv
// Raster sequencer for the 3x3 window reader: computes nine tap addresses and a
// padding mask per output pixel, hands each window to the reader, and waits for it.
module conv_window_addr_gen #(
  parameter int                IMG_W     = 64,
  parameter int                IMG_H     = 64,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                STRIDE    = 1,
  parameter logic [ADDR_W-1:0] PAD_ADDR  = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_ctrlReady,
  input  logic              i_ctrlValid,
  output logic [9*ADDR_W:0] o_addrOut,
  output logic              o_start,
  output logic [8:0]        o_padMask,
  output logic [5:0]        o_row,
  output logic [5:0]        o_col,
  output logic              o_busy,
  output logic              o_done
);

  localparam int         OUT_W    = (IMG_W + STRIDE - 1) / STRIDE;
  localparam int         OUT_H    = (IMG_H + STRIDE - 1) / STRIDE;
  localparam logic [5:0] LAST_COL = 6'(OUT_W - 1);
  localparam logic [5:0] LAST_ROW = 6'(OUT_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [5:0]              row_q, row_d;
  logic [5:0]              col_q, col_d;
  logic [9*ADDR_W-1:0]     addr_q, addr_d;
  logic [8:0]              mask_q, mask_d;

  // Returns {pad, address}. Signed int math keeps row/col -1 from wrapping onto a live pixel.
  function automatic logic [ADDR_W:0] tap_f(input logic [5:0] row, input logic [5:0] col,
                                            input int dy, input int dx);
    int r;
    int c;
    int lin;
    r = int'(row) * STRIDE + dy - 1;
    c = int'(col) * STRIDE + dx - 1;
    if (r < 0 || r >= IMG_H || c < 0 || c >= IMG_W) begin
      return {1'b1, PAD_ADDR};
    end
    lin = int'(BASE_ADDR) + r * IMG_W + c;
    return {1'b0, ADDR_W'(lin)};
  endfunction

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        for (int k = 0; k < 9; k++) begin
          {mask_d[k], addr_d[k*ADDR_W +: ADDR_W]} = tap_f(row_q, col_q, k / 3, k % 3);
        end
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_ctrlReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_ctrlValid) begin
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            state_d = S_DONE;
          end else begin
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 6'd1;
            end else begin
              col_d = col_q + 6'd1;
            end
            state_d = S_CALC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  // Addresses stay frozen outside CALC, so the reader can sample them combinationally.
  assign o_addrOut = {1'b0, addr_q};
  assign o_padMask = mask_q;
  assign o_row     = row_q;
  assign o_col     = col_q;
  assign o_start   = (state_q == S_ISSUE) && i_ctrlReady;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: a 4x4 map swept at stride 1 and stride 2, with a
// randomized reader model and a padded-image reference feeding a window scoreboard.
module tb_conv_window_addr_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 12;

  typedef struct packed {
    logic [5:0]    row;
    logic [5:0]    col;
    logic [9*AW:0] addr;
    logic [8:0]    mask;
  } win_t;

  logic          clk, rst;
  logic          start_a[2], rdy_a[2], vld_a[2];
  logic          ostart_a[2], busy_a[2], done_a[2];
  logic [9*AW:0] addr_a[2];
  logic [8:0]    mask_a[2];
  logic [5:0]    row_a[2], col_a[2];
  logic          hold_rdy[2];
  logic          rnd_rdy;

  win_t exp_q[2][$];
  win_t log_q[2][$];
  int   checks, errors;
  int   starts[2], dones[2], done_exp[2];

  conv_window_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BASE_ADDR(12'h000),
                         .STRIDE(1), .PAD_ADDR(12'hFFF)) dut_s1 (
    .i_clk(clk), .i_reset(rst), .i_start(start_a[0]), .i_ctrlReady(rdy_a[0]),
    .i_ctrlValid(vld_a[0]), .o_addrOut(addr_a[0]), .o_start(ostart_a[0]),
    .o_padMask(mask_a[0]), .o_row(row_a[0]), .o_col(col_a[0]),
    .o_busy(busy_a[0]), .o_done(done_a[0]));

  conv_window_addr_gen #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .BASE_ADDR(12'h000),
                         .STRIDE(2), .PAD_ADDR(12'hFFF)) dut_s2 (
    .i_clk(clk), .i_reset(rst), .i_start(start_a[1]), .i_ctrlReady(rdy_a[1]),
    .i_ctrlValid(vld_a[1]), .o_addrOut(addr_a[1]), .o_start(ostart_a[1]),
    .o_padMask(mask_a[1]), .o_row(row_a[1]), .o_col(col_a[1]),
    .o_busy(busy_a[1]), .o_done(done_a[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the map surrounded by a one-pixel ring of PAD entries; a window is a 3x3 crop.
  function automatic win_t model_win(input int s, input int row, input int col);
    int   pimg[H+2][W+2];
    int   v;
    win_t w;
    for (int y = 0; y < H + 2; y++)
      for (int x = 0; x < W + 2; x++)
        pimg[y][x] = (y >= 1 && y <= H && x >= 1 && x <= W) ? (y - 1) * W + (x - 1) : 'hFFF;
    w.row  = 6'(row);
    w.col  = 6'(col);
    w.addr = '0;
    w.mask = '0;
    for (int k = 0; k < 9; k++) begin
      v = pimg[row * s + k / 3][col * s + k % 3];
      w.addr[k*AW +: AW] = v[AW-1:0];
      w.mask[k] = (v == 'hFFF);
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_zero(input int i, input string nm);
    chk(nm, {addr_a[i], mask_a[i], row_a[i], col_a[i], ostart_a[i], busy_a[i], done_a[i]}, '0);
  endtask

  task automatic check_log(input int i, input string nm, input int row, input int col,
                           input logic [9*AW:0] a, input logic [8:0] m);
    logic found;
    found = 1'b0;
    foreach (log_q[i][j]) begin
      if (!found && log_q[i][j].row == 6'(row) && log_q[i][j].col == 6'(col)) begin
        found = 1'b1;
        chk(nm, {log_q[i][j].addr, log_q[i][j].mask}, {a, m});
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s window (%0d,%0d) never issued", nm, row, col);
    end
  endtask

  task automatic push_frame(input int i, output int n);
    int s;
    s = i + 1;
    n = 0;
    for (int r = 0; r < (H + s - 1) / s; r++)
      for (int c = 0; c < (W + s - 1) / s; c++) begin
        exp_q[i].push_back(model_win(s, r, c));
        n++;
      end
    done_exp[i]++;
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk);
    #1 start_a[i] = 1'b1;
  endtask

  // Finishes a frame while throwing stray i_start pulses at the busy DUT.
  task automatic wait_frame(input int i, input int n, input int d0, input int s0);
    int k;
    for (k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1 start_a[i] = 1'b0;
      if (dones[i] > d0) break;
      if ($urandom_range(0, 15) == 0) start_a[i] = 1'b1;
    end
    start_a[i] = 1'b0;
    if (k == 4000) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout dut=%0d done never seen", i);
      exp_q[i].delete();
      done_exp[i] = 0;
    end
    chk($sformatf("window_count_%0d", i), 128'(starts[i] - s0), 128'(n));
  endtask

  task automatic run_frame(input int i);
    int n, d0, s0;
    push_frame(i, n);
    d0 = dones[i];
    s0 = starts[i];
    pulse_start(i);
    wait_frame(i, n, d0, s0);
  endtask

  // Reader model: random ready, latency 6..12 cycles, stray valids whenever not in WAIT.
  initial begin
    int   cnt[2];
    logic seen[2];
    for (int i = 0; i < 2; i++) begin
      rdy_a[i] = 1'b1;
      vld_a[i] = 1'b0;
      cnt[i]   = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) seen[i] = ostart_a[i];
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        vld_a[i] = 1'b0;
        if (rst) begin
          cnt[i]   = 0;
          rdy_a[i] = 1'b1;
        end else if (seen[i]) begin
          cnt[i]   = $urandom_range(6, 12);
          rdy_a[i] = 1'b0;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) vld_a[i] = 1'b1;
        end else begin
          rdy_a[i] = !hold_rdy[i] && (!rnd_rdy || $urandom_range(0, 3) != 0);
          if ($urandom_range(0, 3) == 0) vld_a[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: scoreboard on each o_start, address hold while the reader works, done accounting.
  initial begin
    logic          holding[2];
    logic [9*AW:0] held_a[2];
    logic [8:0]    held_m[2];
    win_t          cur, e;
    holding[0] = 1'b0;
    holding[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding[0] = 1'b0;
        holding[1] = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (ostart_a[i]) begin
            starts[i]++;
            cur = '{row: row_a[i], col: col_a[i], addr: addr_a[i], mask: mask_a[i]};
            log_q[i].push_back(cur);
            checks++;
            if (exp_q[i].size() == 0) begin
              errors++;
              $display("FAIL unexpected_start dut=%0d row=%0d col=%0d", i, cur.row, cur.col);
            end else begin
              e = exp_q[i].pop_front();
              if (cur != e) begin
                errors++;
                $display("FAIL window dut=%0d actual r%0d c%0d %h m%h required r%0d c%0d %h m%h",
                         i, cur.row, cur.col, cur.addr, cur.mask, e.row, e.col, e.addr, e.mask);
              end
            end
            held_a[i]  = addr_a[i];
            held_m[i]  = mask_a[i];
            holding[i] = 1'b1;
          end else if (holding[i]) begin
            chk($sformatf("addr_hold_%0d", i), {addr_a[i], mask_a[i]}, {held_a[i], held_m[i]});
            if (vld_a[i]) holding[i] = 1'b0;
          end
          if (done_a[i]) begin
            dones[i]++;
            checks++;
            if (done_exp[i] == 0 || exp_q[i].size() != 0 || !busy_a[i]) begin
              errors++;
              $display("FAIL done dut=%0d actual pending=%0d busy=%0d required pending=0 busy=1",
                       i, exp_q[i].size(), busy_a[i]);
            end else begin
              done_exp[i]--;
            end
          end
        end
      end
    end
  end

  initial begin
    int   n, d0, s0, cnt, k;
    win_t w;
    checks  = 0;
    errors  = 0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a[i]  = 1'b0;
      hold_rdy[i] = 1'b0;
      starts[i]   = 0;
      dones[i]    = 0;
      done_exp[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset_s1");
    check_zero(1, "reset_s2");
    rst = 1'b0;

    // Abort mid-WAIT: outputs clear immediately, no done follows.
    push_frame(0, n);
    s0 = starts[0];
    pulse_start(0);
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      #1 start_a[0] = 1'b0;
      if (starts[0] > s0) break;
    end
    chk("first_issue_seen", 128'(k < 200), 128'(1));
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_zero(0, "abort_s1");
    exp_q[0].delete();
    done_exp[0] = 0;
    d0 = dones[0];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    chk("abort_no_done", 128'(dones[0]), 128'(d0));

    log_q[0].delete();
    run_frame(0);
    chk("restart_first_win", {log_q[0][0].row, log_q[0][0].col}, '0);
    check_log(0, "win00_s1", 0, 0,
              {1'b0, 12'h005, 12'h004, 12'hFFF, 12'h001, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF},
              9'h04F);
    check_log(0, "win11_s1", 1, 1,
              {1'b0, 12'd10, 12'd9, 12'd8, 12'd6, 12'd5, 12'd4, 12'd2, 12'd1, 12'd0}, 9'h000);
    check_log(0, "win33_s1", 3, 3,
              {1'b0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'd15, 12'd14, 12'hFFF, 12'd11, 12'd10},
              9'h1E4);

    log_q[1].delete();
    run_frame(1);
    check_log(1, "win11_s2", 1, 1,
              {1'b0, 12'd15, 12'd14, 12'd13, 12'd11, 12'd10, 12'd9, 12'd7, 12'd6, 12'd5}, 9'h000);

    // Reader not ready for several cycles in ISSUE, then exactly one start.
    rnd_rdy     = 1'b0;
    hold_rdy[0] = 1'b1;
    push_frame(0, n);
    d0 = dones[0];
    s0 = starts[0];
    w  = model_win(1, 0, 0);
    pulse_start(0);
    @(posedge clk);
    #1 start_a[0] = 1'b0;
    @(posedge clk);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stall_no_start", {ostart_a[0], busy_a[0]}, {1'b0, 1'b1});
      chk("stall_addr", {addr_a[0], mask_a[0]}, {w.addr, w.mask});
    end
    @(posedge clk);
    #1 hold_rdy[0] = 1'b0;
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (ostart_a[0]) cnt++;
    end
    chk("single_start", 128'(cnt), 128'(1));
    rnd_rdy = 1'b1;
    wait_frame(0, n, d0, s0);

    for (int rep = 0; rep < 4; rep++) run_frame(int'($urandom_range(0, 1)));

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
